// File: rtl/range_seq_driver.sv
// Bounded value-stream generator on a valid/ready interface: up/down/hold sweeps with
// wrap-around, finite or open-ended bursts, and optional periodic out-of-range beats.
module range_seq_driver #(
  parameter int              WIDTH      = 4,
  parameter int              LO         = 4,
  parameter int              HI         = 11,
  parameter logic [WIDTH-1:0] RESET_VAL = 4'b1101,
  parameter int              INJ_PERIOD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [15:0]      len,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             in_range,
  output logic             busy,
  output logic             done,
  output logic [15:0]      beat_cnt,
  output logic [7:0]       inj_cnt
);

  localparam int               MAXV     = (1 << WIDTH) - 1;
  localparam bit               INJ_EN   = (INJ_PERIOD > 0) && !(LO == 0 && HI == MAXV);
  localparam logic [WIDTH-1:0] INJ_VAL  = WIDTH'((HI < MAXV) ? HI + 1 : LO - 1);
  localparam logic [15:0]      INJ_LAST = 16'(INJ_PERIOD - 1);
  localparam logic [WIDTH:0]   LO_X     = (WIDTH+1)'(LO);
  localparam logic [WIDTH:0]   HI_X     = (WIDTH+1)'(HI);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   step_q;
  logic [15:0]      len_q;
  logic [WIDTH-1:0] seq_v;     // current regular sequence value
  logic             cur_inj;   // out_data is an injected beat
  logic [15:0]      reg_cnt;   // regular beats since last injection

  logic             beat, last_beat, inj_due;
  logic [WIDTH:0]   seq_x, sum, up_next, dn_next, next_x;
  logic [WIDTH-1:0] next_v, first_v;
  logic [15:0]      beat_inc, reg_inc;

  assign beat     = out_valid && out_ready;
  assign seq_x    = {1'b0, seq_v};
  assign sum      = seq_x + step_q;
  assign up_next  = (sum > HI_X) ? LO_X : sum;
  assign dn_next  = (seq_x < LO_X + step_q) ? HI_X : seq_x - step_q;
  assign next_x   = (mode_q == 2'b10) ? seq_x : (mode_q == 2'b01) ? dn_next : up_next;
  assign next_v   = WIDTH'(next_x);
  assign first_v  = (mode == 2'b01) ? WIDTH'(HI) : WIDTH'(LO);
  assign beat_inc = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
  assign reg_inc  = reg_cnt + 16'd1;
  assign inj_due  = INJ_EN && (reg_inc == INJ_LAST);
  assign last_beat = (len_q != 16'd0) && (beat_inc == len_q);

  assign in_range = out_valid && ({1'b0, out_data} >= LO_X) && ({1'b0, out_data} <= HI_X);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      step_q    <= '0;
      len_q     <= '0;
      seq_v     <= '0;
      cur_inj   <= 1'b0;
      reg_cnt   <= '0;
      out_data  <= RESET_VAL;
      out_valid <= 1'b0;
      done      <= 1'b0;
      beat_cnt  <= '0;
      inj_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            mode_q    <= mode;
            step_q    <= (step == '0) ? (WIDTH+1)'(1) : {1'b0, step};
            len_q     <= len;
            beat_cnt  <= '0;
            reg_cnt   <= '0;
            seq_v     <= first_v;
            out_valid <= 1'b1;
            if (INJ_EN && INJ_LAST == 16'd0) begin
              out_data <= INJ_VAL;
              cur_inj  <= 1'b1;
            end else begin
              out_data <= first_v;
              cur_inj  <= 1'b0;
            end
          end
        end
        RUN, DRAIN: begin
          if (beat) begin
            beat_cnt <= beat_inc;
            if (cur_inj && inj_cnt != 8'hFF) inj_cnt <= inj_cnt + 8'd1;
            if (last_beat || stop || state == DRAIN) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else if (cur_inj) begin
              // the injected beat leaves the sequence where it was
              out_data <= seq_v;
              cur_inj  <= 1'b0;
              reg_cnt  <= '0;
            end else begin
              seq_v   <= next_v;
              reg_cnt <= reg_inc;
              if (inj_due) begin
                out_data <= INJ_VAL;
                cur_inj  <= 1'b1;
              end else begin
                out_data <= next_v;
              end
            end
          end else if (state == RUN && stop) begin
            state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_seq_driver.sv
// Randomized scoreboard bench: two instances (no injection / injection every 4th beat)
// share stimulus; expected beat streams come from an arithmetic model of the sweep rules.
module tb_range_seq_driver;

  localparam int LO = 4, HI = 11, INJ = 12;

  logic        clk = 1'b0, reset;
  logic        start, stop, out_ready;
  logic [1:0]  mode;
  logic [3:0]  step;
  logic [15:0] len;

  logic [3:0]  d0_data, d1_data;
  logic        d0_valid, d1_valid, d0_inr, d1_inr, d0_busy, d1_busy, d0_done, d1_done;
  logic [15:0] d0_bcnt, d1_bcnt;
  logic [7:0]  d0_icnt, d1_icnt;

  range_seq_driver #(.INJ_PERIOD(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .step(step),
    .len(len), .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
    .in_range(d0_inr), .busy(d0_busy), .done(d0_done), .beat_cnt(d0_bcnt), .inj_cnt(d0_icnt));

  range_seq_driver #(.INJ_PERIOD(4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .step(step),
    .len(len), .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .in_range(d1_inr), .busy(d1_busy), .done(d1_done), .beat_cnt(d1_bcnt), .inj_cnt(d1_icnt));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int beats = 0;
  int inj_total = 0;
  int q0[$], q1[$];

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int nxt(int m, int s, int v);
    if (m == 2) return v;
    if (m == 1) return (v - s < LO) ? HI : v - s;
    return (v + s > HI) ? LO : v + s;
  endfunction

  // expected streams: plain sweep, and the same sweep with every 4th beat replaced
  task automatic push_exp(input int m, input int st, input int n);
    int s, v0, v1, r1;
    s  = (st == 0) ? 1 : st;
    v0 = (m == 1) ? HI : LO;
    v1 = v0;
    r1 = 0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < n; k++) begin
      q0.push_back(v0);
      v0 = nxt(m, s, v0);
      if (r1 == 3) begin
        q1.push_back(INJ);
        r1 = 0;
      end else begin
        q1.push_back(v1);
        v1 = nxt(m, s, v1);
        r1++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && d0_valid && out_ready) begin
      beats++;
      check("valid1", int'(d1_valid), 1);
      if (q0.size() == 0 || q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_beat: got data %0d/%0d expected no beat", d0_data, d1_data);
      end else begin
        int e0, e1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("data0", int'(d0_data), e0);
        check("data1", int'(d1_data), e1);
        check("in_range0", int'(d0_inr), int'(e0 >= LO && e0 <= HI));
        check("in_range1", int'(d1_inr), int'(e1 >= LO && e1 <= HI));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_regs(string tag);
    check({tag, "_valid"}, int'(d0_valid), 0);
    check({tag, "_data"}, int'(d0_data), 13);
    check({tag, "_busy"}, int'(d0_busy), 0);
    check({tag, "_done"}, int'(d0_done), 0);
    check({tag, "_bcnt"}, int'(d0_bcnt), 0);
    check({tag, "_icnt1"}, int'(d1_icnt), 0);
  endtask

  // one burst; len==0 bursts are ended by stop once stop_after beats were accepted
  task automatic run_burst(input int m, input int st, input int ln, input int stop_after,
                           input int ready_pct);
    bit got_done, stopped;
    push_exp(m, st, (ln == 0) ? 64 : ln);
    beats = 0;
    got_done = 0;
    stopped = 0;
    start = 1; mode = 2'(m); step = 4'(st); len = 16'(ln);
    out_ready = ($urandom_range(99) < ready_pct);
    tick();
    start = 0;
    for (int c = 0; c < 600 && !got_done; c++) begin
      out_ready = ($urandom_range(99) < ready_pct) || (c % 8 == 7);
      stop = (ln == 0 && !stopped && beats >= stop_after);
      if (stop) stopped = 1;
      tick();
      stop = 0;
      if (d0_done) got_done = 1;
    end
    check("done_seen", int'(got_done), 1);
    check("done1", int'(d1_done), int'(got_done));
    check("busy_end", int'(d0_busy), 0);
    check("valid_end", int'(d0_valid), 0);
    if (ln != 0) begin
      check("beat_cnt", int'(d0_bcnt), ln);
      check("all_consumed", q0.size(), 0);
    end else begin
      check("beat_cnt", int'(d0_bcnt), beats);
    end
    check("beat_cnt1", int'(d1_bcnt), int'(d0_bcnt));
    inj_total += beats / 4;
    check("inj_cnt1", int'(d1_icnt), inj_total);
    check("inj_cnt0", int'(d0_icnt), 0);
    out_ready = 0;
    tick();
    check("done_pulse", int'(d0_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; stop = 0; mode = 0; step = 0; len = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_regs("reset");
    reset = 0;
    tick();

    run_burst(0, 1, 10, 0, 100);   // 4..11,4,5
    run_burst(1, 3, 5, 0, 100);    // 11,8,5,11,8
    run_burst(0, 1, 8, 0, 100);    // injected stream 4,5,6,12,7,8,9,12

    // stall at value 6, then stop with no beat -> drain
    push_exp(0, 1, 64);
    beats = 0;
    start = 1; mode = 0; step = 1; len = 0; out_ready = 0;
    tick();
    start = 0; out_ready = 1;
    tick();
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data", int'(d0_data), 6);
      check("stall_valid", int'(d0_valid), 1);
    end
    stop = 1;
    tick();
    stop = 0;
    check("drain_busy", int'(d0_busy), 1);
    check("drain_data", int'(d0_data), 6);
    out_ready = 1;
    tick();
    check("drain_done", int'(d0_done), 1);
    check("drain_valid", int'(d0_valid), 0);
    check("drain_bcnt", int'(d0_bcnt), 3);
    out_ready = 0;
    tick();

    // start and stop together, then reset mid-burst
    push_exp(0, 1, 64);
    start = 1; stop = 1; mode = 0; step = 1; len = 0;
    tick();
    start = 0; stop = 0;
    check("startstop_busy", int'(d0_busy), 1);
    check("startstop_valid", int'(d0_valid), 1);
    out_ready = 1;
    tick();
    tick();
    #2 reset = 1;
    #1;
    check_idle_regs("midreset");
    q0.delete();
    q1.delete();
    inj_total = 0;
    out_ready = 0;
    tick();
    reset = 0;
    tick();

    run_burst(0, 0, 12, 0, 100);   // step 0 acts as 1
    run_burst(2, 5, 3, 0, 100);    // hold: 4,4,4

    for (int b = 0; b < 14; b++) begin
      int ln;
      ln = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(20, 1));
      run_burst(int'($urandom_range(3)), int'($urandom_range(15)), ln,
                int'($urandom_range(25, 1)), int'($urandom_range(100, 40)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
